// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: fetches sequential words from the instruction
// bus into a small FIFO of {instr, pc} pairs and hands them to if_id.
// Jumps and JTAG resets flush the FIFO; a bus request left in flight by a
// flush is completed and its data dropped (StDrop).
// Optional feature: define PREFETCH_BYPASS_EN to forward a returning bus word
// straight to instr_o/pc_o when the FIFO is empty and if_id is ready.
module instr_prefetch_buf #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ready_i,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              jtag_reset_flag_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0]   DepthCnt = (PtrW+1)'(DEPTH);

  typedef enum logic [0:0] {StFetch, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] stale_addr_q, stale_addr_d;
  // A request was on the bus last cycle and has not completed yet.
  logic              req_pend_q;

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;

  logic              flush;
  logic [ADDR_W-1:0] flush_target;
  logic              fifo_valid, fifo_full, fifo_pop;
  logic              push, push_fifo, bypass;

  assign flush        = jump_flag_i | jtag_reset_flag_i;
  assign flush_target = jtag_reset_flag_i ? RESET_PC : jump_addr_i;
  assign fifo_valid   = (count_q != '0);
  assign fifo_full    = (count_q == DepthCnt);
  assign fifo_pop     = fifo_valid & instr_ready_i;

`ifdef PREFETCH_BYPASS_EN
  // Word goes straight to if_id instead of into the empty FIFO.
  assign bypass = ~fifo_valid & instr_ready_i & push;
`else
  assign bypass = 1'b0;
`endif
  assign push_fifo = push & ~bypass;

  // Fetch FSM next state, bus request and fetch PC update.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    bus_req_o    = 1'b0;
    bus_addr_o   = fetch_pc_q;
    push         = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus_req_o = rst_ni & ~flush & (~fifo_full | fifo_pop);
        push      = bus_req_o & bus_ready_i;
        if (flush) begin
          fetch_pc_d = flush_target;
          // A word returning in the flush cycle is simply discarded.
          if (req_pend_q && !bus_ready_i) begin
            state_d      = StDrop;
            stale_addr_d = fetch_pc_q;
          end
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
      end
      StDrop: begin
        bus_req_o  = rst_ni;
        bus_addr_o = stale_addr_q;
        if (flush) begin
          fetch_pc_d = flush_target;
        end
        if (bus_ready_i) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // FSM, fetch PC and outstanding-request tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StFetch;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
      req_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      req_pend_q   <= bus_req_o & ~bus_ready_i;
    end
  end

  // FIFO storage; contents are don't-care while not counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_fifo) begin
      instr_mem_q[wr_ptr_q] <= bus_data_i;
      pc_mem_q[wr_ptr_q]    <= bus_addr_o;
    end
  end

  // FIFO pointers and occupancy; a flush empties it in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fifo) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + (PtrW+1)'(push_fifo) - (PtrW+1)'(fifo_pop);
    end
  end

  // Head of FIFO toward if_id; outputs read as zero while nothing is valid.
  always_comb begin
    instr_valid_o = fifo_valid;
    instr_o       = fifo_valid ? instr_mem_q[rd_ptr_q] : '0;
    pc_o          = fifo_valid ? pc_mem_q[rd_ptr_q] : '0;
`ifdef PREFETCH_BYPASS_EN
    if (bypass) begin
      instr_valid_o = 1'b1;
      instr_o       = bus_data_i;
      pc_o          = bus_addr_o;
    end
`endif
    pc_next_o = instr_valid_o ? pc_o + ADDR_W'(4) : '0;
  end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Randomised bench for instr_prefetch_buf. The reference model describes the
// expected instruction stream: after each redirect, consecutive words from the
// target address; a bus transfer that was in flight at a redirect is never
// delivered. Expected pairs are queued on each bus completion; a separate
// monitor pops and compares whenever if_id accepts an instruction.
module tb_instr_prefetch_buf;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0040;
`ifdef PREFETCH_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk, rst_n;
  logic        bus_req_o, bus_ready_i;
  logic [31:0] bus_addr_o, bus_data_i;
  logic        jump_flag_i, jtag_reset_flag_i;
  logic [31:0] jump_addr_i;
  logic        instr_valid_o, instr_ready_i;
  logic [31:0] instr_o, pc_o, pc_next_o;

  instr_prefetch_buf #(
    .DEPTH   (DEPTH),
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bus_req_o        (bus_req_o),
    .bus_addr_o       (bus_addr_o),
    .bus_ready_i      (bus_ready_i),
    .bus_data_i       (bus_data_i),
    .jump_flag_i      (jump_flag_i),
    .jump_addr_i      (jump_addr_i),
    .jtag_reset_flag_i(jtag_reset_flag_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .pc_next_o        (pc_next_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc;          // next address the stream should deliver
  logic [31:0] m_stale_addr;  // address of the in-flight transfer to drop
  bit          m_stale;       // an in-flight transfer must be dropped
  bit          m_pend;        // bus has accepted a request not yet answered

  // Instruction memory contents seen by the bus.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    rst_n             = 1'b0;
    bus_ready_i       = 1'b0;
    bus_data_i        = '0;
    jump_flag_i       = 1'b0;
    jtag_reset_flag_i = 1'b0;
    jump_addr_i       = '0;
    instr_ready_i     = 1'b0;
    #1;
    check("rst_instr_valid", instr_valid_o, 0);
    check("rst_bus_req", bus_req_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_pc_next", pc_next_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_pc    = RST_PC;
    m_stale = 1'b0;
    m_pend  = 1'b0;
  endtask

  // One clock cycle of stimulus; percentages for each random input.
  task automatic cycle(input int p_rdy, input int p_bus, input int p_jmp, input int p_jtag);
    logic flush, keep, valid_exp, pop_exp, req_exp;
    int   sz;
    instr_ready_i     = ($urandom_range(99) < p_rdy);
    jump_flag_i       = ($urandom_range(99) < p_jmp);
    jtag_reset_flag_i = ($urandom_range(99) < p_jtag);
    jump_addr_i       = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
    #1;
    // Bus responder: may answer only a request it has seen.
    bus_ready_i = (bus_req_o || m_pend) && ($urandom_range(99) < p_bus);
    bus_data_i  = mem_word(bus_addr_o);
    #1;
    flush     = jump_flag_i || jtag_reset_flag_i;
    sz        = exp_q.size();
    keep      = bus_ready_i && !flush && !m_stale;
    valid_exp = (sz > 0) || (Bypass && keep && instr_ready_i);
    pop_exp   = valid_exp && instr_ready_i;
    req_exp   = m_stale || (!flush && (sz < DEPTH || pop_exp));
    check("instr_valid", instr_valid_o, valid_exp);
    check("bus_req", bus_req_o, req_exp);
    if (req_exp) check("bus_addr", bus_addr_o, m_stale ? m_stale_addr : m_pc);
    if (keep) begin
      if (sz >= DEPTH && !pop_exp) begin
        n_cmp++;
        n_err++;
        $display("FAIL fifo_overflow: push with %0d entries held, limit %0d", sz, DEPTH);
      end
      exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
      m_pc += 32'd4;
    end
    #2;  // monitor has popped by now
    if (flush) begin
      if (!m_stale && m_pend && !bus_ready_i) m_stale_addr = m_pc;
      m_stale = m_pend && !bus_ready_i;
      m_pc    = jtag_reset_flag_i ? RST_PC : jump_addr_i;
      exp_q.delete();
    end else if (bus_ready_i) begin
      m_stale = 1'b0;
    end
    m_pend = (bus_req_o || m_pend) && !bus_ready_i;
    @(negedge clk);
  endtask

  // Monitor: compare every accepted instruction against the scoreboard.
  always @(negedge clk) begin
    #3;
    if (rst_n && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got pc %h, expected no instruction", pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("instr", instr_o, mon_e.instr);
        check("pc", pc_o, mon_e.pc);
        check("pc_next", pc_next_o, mon_e.pc + 32'd4);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (30) cycle(100, 100, 0, 0);    // streaming from reset PC
    repeat (15) cycle(0, 100, 0, 0);      // consumer stalled: fill and stop
    repeat (20) cycle(100, 100, 0, 0);    // resume
    repeat (2000) cycle(60, 50, 5, 1);    // mixed traffic
    repeat (1000) cycle(70, 20, 12, 3);   // slow bus, frequent redirects
    repeat (20) cycle(100, 30, 0, 0);
    do_reset();                           // likely mid-request
    repeat (500) cycle(50, 60, 6, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
